// File: rtl/wb_burst_master_pkg.sv
// Shared constants and types for the Wishbone burst master.
package wb_burst_master_pkg;

  localparam int ADR_W = 19;
  localparam logic [1:0] SEL_ALL = 2'b11;

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_ISSUE = 2'd1;
  localparam logic [1:0] S_DRAIN = 2'd2;
  localparam logic [1:0] S_DONE  = 2'd3;

  typedef struct packed {
    logic             we;
    logic [ADR_W-1:0] base;
  } cmd_t;

endpackage

// File: rtl/wb_burst_master.sv
// Wishbone B4 pipelined burst initiator moving a run of 16-bit words
// between a write stream / read stream and consecutive bus addresses.
module wb_burst_master
  import wb_burst_master_pkg::*;
#(
  parameter int CNT_W = 16
) (
  input  logic             clk_i,
  input  logic             reset_i,
  input  logic             start_i,
  input  logic             write_i,
  input  logic [ADR_W:1]   base_i,
  input  logic [CNT_W-1:0] count_i,
  output logic             busy_o,
  output logic             done_o,
  input  logic [15:0]      wdat_i,
  input  logic             wvalid_i,
  output logic             wready_o,
  output logic [15:0]      rdat_o,
  output logic             rvalid_o,
  output logic             cyc_o,
  output logic             stb_o,
  output logic             we_o,
  output logic [1:0]       sel_o,
  output logic [ADR_W:1]   adr_o,
  output logic [15:0]      dat_o,
  input  logic             ack_i,
  input  logic             stall_i,
  input  logic [15:0]      dat_i
);

  logic [1:0]       state;
  cmd_t             cmd;
  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] issued;
  logic [CNT_W-1:0] acks;
  logic             more;
  logic             take;
  logic             load;
  logic             ack_ok;

  assign more   = issued != cnt;
  assign take   = ~stb_o | ~stall_i;
  assign load   = (state == S_ISSUE) & take & more
                & (~cmd.we | wvalid_i);
  assign ack_ok = ack_i & cyc_o;

  assign wready_o = load & cmd.we;
  assign cyc_o    = (state == S_ISSUE) | (state == S_DRAIN);
  assign busy_o   = state != S_IDLE;
  assign done_o   = state == S_DONE;
  assign sel_o    = SEL_ALL;

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      state    <= S_IDLE;
      cmd      <= '0;
      cnt      <= '0;
      issued   <= '0;
      acks     <= '0;
      stb_o    <= 1'b0;
      we_o     <= 1'b0;
      adr_o    <= '0;
      dat_o    <= '0;
      rdat_o   <= '0;
      rvalid_o <= 1'b0;
    end else begin
      rvalid_o <= ack_ok & ~cmd.we;
      if (ack_ok & ~cmd.we) rdat_o <= dat_i;
      if (ack_ok) acks <= acks + 1'b1;

      // a held request only retires once the slave stops stalling
      if (load) begin
        stb_o  <= 1'b1;
        adr_o  <= cmd.base + ADR_W'(issued);
        dat_o  <= wdat_i;
        issued <= issued + 1'b1;
      end else if (~stall_i) begin
        stb_o  <= 1'b0;
      end

      unique case (state)
        S_IDLE: begin
          if (start_i) begin
            if (count_i != '0) begin
              cmd    <= '{we: write_i, base: base_i};
              cnt    <= count_i;
              issued <= '0;
              acks   <= '0;
              we_o   <= write_i;
              state  <= S_ISSUE;
            end else begin
              state  <= S_DONE;
            end
          end
        end
        S_ISSUE: if (~more & take) state <= S_DRAIN;
        S_DRAIN: if (acks == cnt) state <= S_DONE;
        S_DONE: begin
          we_o  <= 1'b0;
          state <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_wb_burst_master.sv
// Bench: pipelined slave + write source, transaction-level model,
// per-cycle compare and directed literal checks.
module tb_wb_burst_master;

  logic        clk = 1'b0;
  logic        reset_i = 1'b1;
  logic        start_i = 1'b0;
  logic        write_i = 1'b0;
  logic [19:1] base_i = '0;
  logic [15:0] count_i = '0;
  logic        busy_o, done_o;
  logic [15:0] wdat_i = '0;
  logic        wvalid_i = 1'b0;
  logic        wready_o;
  logic [15:0] rdat_o;
  logic        rvalid_o;
  logic        cyc_o, stb_o, we_o;
  logic [1:0]  sel_o;
  logic [19:1] adr_o;
  logic [15:0] dat_o;
  logic        ack_i = 1'b0;
  logic        stall_i = 1'b0;
  logic [15:0] dat_i = '0;

  wb_burst_master #(.CNT_W(16)) dut (
    .clk_i(clk), .reset_i(reset_i), .start_i(start_i),
    .write_i(write_i), .base_i(base_i), .count_i(count_i),
    .busy_o(busy_o), .done_o(done_o), .wdat_i(wdat_i),
    .wvalid_i(wvalid_i), .wready_o(wready_o), .rdat_o(rdat_o),
    .rvalid_o(rvalid_o), .cyc_o(cyc_o), .stb_o(stb_o),
    .we_o(we_o), .sel_o(sel_o), .adr_o(adr_o), .dat_o(dat_o),
    .ack_i(ack_i), .stall_i(stall_i), .dat_i(dat_i)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad = 0;
  int cyc_n = 0;
  always @(posedge clk) cyc_n++;

  task automatic chk(input string nm, input logic [31:0] got,
                     input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", nm, got, exp);
    end
  endtask

  // slave and write-source state
  int          stall_left = 0;
  bit          rd_fixed = 1'b1;
  int          rd_seq = 0;
  bit          pend_ack = 1'b0;
  logic [15:0] wwords [16];
  int          src_n = 0;
  int          widx = 0;
  int          gap_idx = -1;
  bit          gap_done = 1'b0;
  bit          xfer_prev = 1'b0;

  // transaction model
  bit          m_active = 1'b0;
  bit          m_we = 1'b0;
  logic [18:0] m_base = '0;
  int          m_cnt = 0, m_k = 0, m_acks = 0;
  bit          exp_rv = 1'b0;
  logic [15:0] exp_rd = '0;
  int          first_stb = -1, done_cyc = 0, st_cyc = 0;
  int          rv_cnt = 0, done_cnt = 0;
  bit          cyc_seen = 1'b0;
  bit          done_now;
  int          acc_cyc [16];
  logic [18:0] acc_adr [16];
  logic [15:0] acc_dat [16];
  logic [18:0] ea;

  always @(negedge clk) begin
    ack_i = pend_ack;
    if (pend_ack) begin
      dat_i = rd_fixed ? 16'hF00D : 16'hA500 + 16'(rd_seq);
      rd_seq++;
    end
    stall_i = stb_o && stall_left > 0;
    if (stall_i) stall_left--;
    if (xfer_prev) widx++;
    if (widx == gap_idx && !gap_done) begin
      wvalid_i = 1'b0;
      gap_done = 1'b1;
    end else begin
      wvalid_i = widx < src_n;
    end
    wdat_i = (widx < 16) ? wwords[widx] : 16'h0;
    #1;
    xfer_prev = wvalid_i & wready_o;
    pend_ack  = stb_o & ~stall_i & cyc_o;
    if (reset_i) begin
      m_active = 1'b0;
      exp_rv   = 1'b0;
    end else begin
      chk("busy", 32'(busy_o), 32'(m_active));
      chk("sel", 32'(sel_o), 32'h3);
      chk("rvalid", 32'(rvalid_o), 32'(exp_rv));
      if (exp_rv) begin
        chk("rdat", 32'(rdat_o), 32'(exp_rd));
        rv_cnt++;
      end
      exp_rv = 1'b0;
      if (ack_i && m_active) begin
        m_acks++;
        if (!m_we) begin
          exp_rv = 1'b1;
          exp_rd = dat_i;
        end
      end
      if (cyc_o) cyc_seen = 1'b1;
      if (stb_o && first_stb < 0) first_stb = cyc_n;
      if (stb_o && !stall_i && cyc_o) begin
        chk("acc_in_range", 32'(m_k < m_cnt), 32'h1);
        ea = m_base + 19'(m_k);
        chk("acc_adr", 32'(adr_o), 32'(ea));
        chk("acc_we", 32'(we_o), 32'(m_we));
        if (m_k < 16) begin
          if (m_we) chk("acc_dat", 32'(dat_o), 32'(wwords[m_k]));
          acc_cyc[m_k] = cyc_n;
          acc_adr[m_k] = adr_o;
          acc_dat[m_k] = dat_o;
        end
        m_k++;
      end
      if (wready_o) chk("wready_mode", 32'(m_active && m_we), 32'h1);
      done_now = done_o;
      if (done_o) begin
        chk("done_when",
            32'(m_active && m_acks == m_cnt && m_k == m_cnt), 32'h1);
        done_cyc = cyc_n;
        done_cnt++;
        m_active = 1'b0;
      end
      if (!m_active) begin
        chk("idle_cyc", 32'(cyc_o), 32'h0);
        chk("idle_stb", 32'(stb_o), 32'h0);
      end
      if (start_i && !m_active && !done_now) begin
        m_active  = 1'b1;
        m_we      = write_i;
        m_base    = base_i;
        m_cnt     = int'(count_i);
        m_k       = 0;
        m_acks    = 0;
        first_stb = -1;
        rv_cnt    = 0;
        cyc_seen  = 1'b0;
        st_cyc    = cyc_n;
      end
    end
  end

  task automatic wait_done(input int d0);
    int i;
    i = 0;
    while (done_cnt == d0 && i < 300) begin
      @(posedge clk);
      i++;
    end
    repeat (2) @(posedge clk);
    chk("done_pulses", 32'(done_cnt - d0), 32'h1);
  endtask

  task automatic run_cmd(input bit we, input logic [18:0] base,
                         input int n, input bit wt);
    int d0;
    d0 = done_cnt;
    @(posedge clk); #2;
    write_i = we;
    base_i  = base;
    count_i = 16'(n);
    start_i = 1'b1;
    @(posedge clk); #2;
    start_i = 1'b0;
    if (wt) wait_done(d0);
  endtask

  task automatic src_reset(input int n, input int gap);
    widx      = 0;
    xfer_prev = 1'b0;
    src_n     = n;
    gap_idx   = gap;
    gap_done  = 1'b0;
  endtask

  initial begin
    int d0, d1, i;
    for (int j = 0; j < 16; j++) wwords[j] = 16'h0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_cyc", 32'(cyc_o), 0);
    chk("rst_stb", 32'(stb_o), 0);
    chk("rst_we", 32'(we_o), 0);
    chk("rst_busy", 32'(busy_o), 0);
    chk("rst_done", 32'(done_o), 0);
    chk("rst_wready", 32'(wready_o), 0);
    chk("rst_rvalid", 32'(rvalid_o), 0);
    chk("rst_adr", 32'(adr_o), 0);
    chk("rst_dat", 32'(dat_o), 0);
    chk("rst_rdat", 32'(rdat_o), 0);
    #1 reset_i = 1'b0;

    // zero-wait read burst of four
    rd_fixed = 1'b1;
    run_cmd(1'b0, 19'h00010, 4, 1'b1);
    chk("rd4_latency", 32'(done_cyc - first_stb), 32'd6);
    chk("rd4_adr0", 32'(acc_adr[0]), 32'h10);
    chk("rd4_adr3", 32'(acc_adr[3]), 32'h13);
    chk("rd4_back2back", 32'(acc_cyc[3] - acc_cyc[0]), 32'd3);
    chk("rd4_rvalids", 32'(rv_cnt), 32'd4);
    chk("rd4_rdat", 32'(rdat_o), 32'hF00D);

    // write of three with a one-cycle source gap after word 1
    wwords[0] = 16'h1111;
    wwords[1] = 16'h2222;
    wwords[2] = 16'h3333;
    src_reset(3, 1);
    run_cmd(1'b1, 19'h00100, 3, 1'b1);
    chk("wr_gap", 32'(acc_cyc[1] - acc_cyc[0]), 32'd2);
    chk("wr_nogap", 32'(acc_cyc[2] - acc_cyc[1]), 32'd1);
    chk("wr_last_dat", 32'(acc_dat[2]), 32'h3333);
    chk("wr_acks", 32'(m_acks), 32'd3);
    src_reset(0, -1);

    // first request stalled three cycles
    rd_fixed   = 1'b0;
    stall_left = 3;
    run_cmd(1'b0, 19'h00200, 2, 1'b1);
    chk("stall_hold", 32'(acc_cyc[0] - first_stb), 32'd3);
    chk("stall_acks", 32'(m_acks), 32'd2);
    chk("stall_rvalids", 32'(rv_cnt), 32'd2);

    // address wrap
    run_cmd(1'b0, 19'h7FFFF, 2, 1'b1);
    chk("wrap_adr0", 32'(acc_adr[0]), 32'h7FFFF);
    chk("wrap_adr1", 32'(acc_adr[1]), 32'h00000);

    // zero-length command
    run_cmd(1'b0, 19'h00300, 0, 1'b1);
    chk("zero_done_lat", 32'(done_cyc - st_cyc), 32'd1);
    chk("zero_no_cyc", 32'(cyc_seen), 32'd0);

    // start while busy is ignored
    d0 = done_cnt;
    run_cmd(1'b0, 19'h00040, 2, 1'b0);
    write_i = 1'b1;
    base_i  = 19'h00099;
    count_i = 16'd5;
    start_i = 1'b1;
    @(posedge clk); #2;
    start_i = 1'b0;
    wait_done(d0);
    chk("busy_start_k", 32'(m_k), 32'd2);
    chk("busy_start_acks", 32'(m_acks), 32'd2);

    // reset after two of four acks
    run_cmd(1'b0, 19'h00500, 4, 1'b0);
    i = 0;
    while (m_acks < 2 && i < 100) begin
      @(negedge clk); #2;
      i++;
    end
    chk("mid_two_acks", 32'(m_acks), 32'd2);
    @(posedge clk); #2;
    reset_i = 1'b1;
    #1;
    chk("mid_rst_cyc", 32'(cyc_o), 0);
    chk("mid_rst_stb", 32'(stb_o), 0);
    chk("mid_rst_busy", 32'(busy_o), 0);
    d1 = done_cnt;
    repeat (2) @(posedge clk);
    #2 reset_i = 1'b0;
    repeat (6) @(posedge clk);
    chk("mid_no_done", 32'(done_cnt - d1), 32'd0);
    wwords[0] = 16'hBEEF;
    wwords[1] = 16'hCAFE;
    wwords[2] = 16'h0123;
    src_reset(3, -1);
    run_cmd(1'b1, 19'h00050, 3, 1'b1);
    chk("post_rst_acks", 32'(m_acks), 32'd3);
    chk("post_rst_dat", 32'(acc_dat[1]), 32'hCAFE);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/wb_burst_master.md
WB_BURST_MASTER -- requirements
Module: wb_burst_master

Interface
REQ-001 SHALL have parameter CNT_W, default 16, width of word-count and issue/ack counters.
REQ-002 SHALL have port clk_i  in  1  single clock; all logic on posedge.
REQ-003 SHALL have port reset_i  in  1  asynchronous, active-high reset.
REQ-004 SHALL have port start_i  in  1  command strobe, sampled only in IDLE.
REQ-005 SHALL have port write_i  in  1  command direction (1 = write, 0 = read), sampled with start_i.
REQ-006 SHALL have port base_i  in  19 [19:1]  first word address, sampled with start_i.
REQ-007 SHALL have port count_i  in  CNT_W  number of 16-bit words, sampled with start_i.
REQ-008 SHALL have port busy_o  out  1  high from the cycle after start is accepted until DONE.
REQ-009 SHALL have port done_o  out  1  one-cycle completion pulse.
REQ-010 SHALL have ports wdat_i in 16, wvalid_i in 1, wready_o out 1  write-data stream; transfer when wvalid_i & wready_o.
REQ-011 SHALL have ports rdat_o out 16, rvalid_o out 1  read-data stream; no backpressure.
REQ-012 SHALL have Wishbone B4 pipelined initiator ports cyc_o, stb_o, we_o out 1; sel_o out 2; adr_o out 19 [19:1]; dat_o out 16; ack_i, stall_i in 1; dat_i in 16.

Function
REQ-013 SHALL implement states IDLE, ISSUE, DRAIN, DONE.
REQ-014 IDLE: start_i with count_i != 0 SHALL latch command, clear issue and ack counters, go to ISSUE; count_i == 0 SHALL go straight to DONE with no bus cycle.
REQ-015 start_i outside IDLE SHALL be ignored.
REQ-016 cyc_o SHALL be high in ISSUE and DRAIN only; sel_o SHALL be 2'b11 always.
REQ-017 stb_o, adr_o, dat_o, we_o SHALL be registered; a new request loads when (~stb_o | ~stall_i) and issued < count and (read, or wvalid_i high).
REQ-018 wready_o SHALL equal the load condition of REQ-017 in write mode; 0 otherwise.
REQ-019 adr_o SHALL be base + issued, wrapping modulo 2^19.
REQ-020 stb_o, adr_o, dat_o SHALL hold while stall_i is high and stb_o is high.
REQ-021 stb_o SHALL drop when the last request is accepted and no new one loads; state then moves to DRAIN.
REQ-022 Each ack_i high while cyc_o is high SHALL increment the ack counter; ack_i while cyc_o is low SHALL be ignored.
REQ-023 Read mode: each counted ack SHALL produce rvalid_o = 1 with rdat_o = dat_i on the following cycle.
REQ-024 DRAIN SHALL go to DONE when acks == count; DONE SHALL assert done_o for one cycle, drop cyc_o, and return to IDLE.
REQ-025 Ack and new issue in the same cycle SHALL both be counted.
REQ-026 With a zero-wait responder that never stalls, N words SHALL complete with done_o N+2 cycles after the first stb_o.

Reset
REQ-027 reset_i SHALL immediately force IDLE, cyc_o = stb_o = we_o = 0, busy_o = done_o = wready_o = rvalid_o = 0, adr_o = dat_o = rdat_o = 0, counters = 0.
REQ-028 Reset mid-burst SHALL abandon the burst with no done_o; outstanding acks arriving after reset SHALL be ignored.

Structure
REQ-029 Shared package SHALL hold the state encoding, SEL_ALL = 2'b11, and the address width constant (19).
REQ-030 Block SHALL be a single module; no sub-module.

Verification
REQ-031 Read, base 0x00010, count 4, zero-wait never-stalling SRAM bridge returning 0xF00D -> adr_o 0x10..0x13 on consecutive cycles, four rvalid_o pulses of 0xF00D, one done_o.
REQ-032 Write, count 3, wvalid_i gapped one cycle after word 1 -> stb_o gaps one cycle, dat_o order preserved, done_o after 3rd ack.
REQ-033 Read, count 2, stall_i high 3 cycles on first request -> adr_o held at base for 4 cycles, exactly 2 acks counted.
REQ-034 Base 0x7FFFF, count 2 -> adr_o 0x7FFFF then 0x00000.
REQ-035 count 0 -> done_o one cycle later, cyc_o never asserted; start_i during busy -> ignored.
REQ-036 reset_i asserted after 2 of 4 words -> cyc_o low same cycle, no done_o; new command afterwards completes normally.
